// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master. Each accepted bus word is shifted out MSB first
// inside one chip-select frame, and the word returned on MISO in the same frame
// is presented on the bus master side with a one-cycle valid pulse.
// SCLK half-period is HALF = FPGA_CLK/(2*SPI_CLK) system clock cycles.
// Optional build macro: SPI_MASTER_MISO_SYNC_EN. When it is defined, MISO passes
// through a two-flop synchroniser before it is sampled. Frame timing is the same
// in both builds.
module spi_master #(
    parameter int DATA_SIZE = 16,
    parameter int FPGA_CLK  = 12_000_000,
    parameter int SPI_CLK   = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 cs_o,
    output logic                 spi_sclk_o,
    output logic                 spi_mosi_o,
    input  logic                 spi_miso_i,
    input  logic                 bus_slv_valid_i,
    input  logic [DATA_SIZE-1:0] bus_slv_data_i,
    output logic                 bus_slv_ready_o,
    output logic                 bus_mst_valid_o,
    output logic [DATA_SIZE-1:0] bus_mst_data_o
);

    localparam int HALF = FPGA_CLK / (2 * SPI_CLK);
    localparam int CW   = $clog2(HALF);
    localparam int BW   = $clog2(DATA_SIZE);
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_SIZE - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [BW-1:0]          bit_q;
    logic [DATA_SIZE-1:0]   tx_q;
    logic [DATA_SIZE-1:0]   rx_q;
    logic                   cs_q;
    logic                   sclk_q;
    logic                   mosi_q;
    logic                   ready_q;
    logic                   mst_valid_q;
    logic [DATA_SIZE-1:0]   mst_data_q;

    logic                   miso_smp_s;
    logic [DATA_SIZE-1:0]   tx_d;
    logic [DATA_SIZE-1:0]   rx_d;

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic miso_sync1_q;
    logic miso_sync2_q;

    // Two-flop synchroniser; the sample seen at a rising edge is MISO from two cycles earlier.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miso_sync1_q <= 1'b0;
            miso_sync2_q <= 1'b0;
        end else begin
            miso_sync1_q <= spi_miso_i;
            miso_sync2_q <= miso_sync1_q;
        end
    end

    assign miso_smp_s = miso_sync2_q;
`else
    assign miso_smp_s = spi_miso_i;
`endif

    // Next value of the shift registers: TX moves toward the MSB, RX takes the new bit at the LSB.
    assign tx_d = {tx_q[DATA_SIZE-2:0], 1'b0};
    assign rx_d = {rx_q[DATA_SIZE-2:0], miso_smp_s};

    // Frame sequencer: every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b0;
            mst_valid_q <= 1'b0;
            mst_data_q  <= '0;
        end else begin
            mst_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus_slv_valid_i && ready_q) begin
                        tx_q    <= bus_slv_data_i;
                        mosi_q  <= bus_slv_data_i[DATA_SIZE-1];
                        cs_q    <= 1'b0;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_SETUP;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == HALF_M1) begin
                        // First rising edge: MISO was set up by the slave when CS fell.
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        sclk_q  <= 1'b1;
                        rx_q    <= rx_d;
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (sclk_q) begin
                            // Falling edge: present the next TX bit if any remain.
                            sclk_q <= 1'b0;
                            if (bit_q == LAST_BIT) begin
                                state_q <= ST_HOLD;
                            end else begin
                                mosi_q <= tx_q[DATA_SIZE-2];
                                tx_q   <= tx_d;
                                bit_q  <= bit_q + BW'(1);
                            end
                        end else begin
                            // Rising edge: capture the slave's bit.
                            sclk_q <= 1'b1;
                            rx_q   <= rx_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q       <= '0;
                        cs_q        <= 1'b1;
                        mst_data_q  <= rx_q;
                        mst_valid_q <= 1'b1;
                        state_q     <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    cs_q    <= 1'b1;
                    sclk_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cs_o            = cs_q;
    assign spi_sclk_o      = sclk_q;
    assign spi_mosi_o      = mosi_q;
    assign bus_slv_ready_o = ready_q;
    assign bus_mst_valid_o = mst_valid_q;
    assign bus_mst_data_o  = mst_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master at default parameters. A behavioural SPI
// slave drives MISO (updating 3 cycles after each SCLK fall) and records MOSI at
// SCLK rises; frame waveforms are predicted from closed-form cycle formulas.
module tb_spi_master;

    localparam int DS        = 16;
    localparam int H         = 12_000_000 / (2 * 1_000_000);
    localparam int T_LASTF   = 1 + 2 * DS * H;
    localparam int T_VALID   = 1 + (2 * DS + 1) * H;
    localparam int T_READY   = 1 + (2 * DS + 2) * H;

    logic          clk;
    logic          rst_n;
    logic          cs;
    logic          sclk;
    logic          mosi;
    logic          miso = 1'b0;
    logic          valid;
    logic [DS-1:0] data;
    logic          ready;
    logic          mvalid;
    logic [DS-1:0] mdata;

    int n_checks = 0;
    int n_pass   = 0;

    spi_master dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cs_o            (cs),
        .spi_sclk_o      (sclk),
        .spi_mosi_o      (mosi),
        .spi_miso_i      (miso),
        .bus_slv_valid_i (valid),
        .bus_slv_data_i  (data),
        .bus_slv_ready_o (ready),
        .bus_mst_valid_o (mvalid),
        .bus_mst_data_o  (mdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slave, evaluated mid-cycle on the falling clk edge.
    logic [DS-1:0] slv_word = '0;
    logic [DS-1:0] slv_sh   = '0;
    logic [DS-1:0] mosi_word = '0;
    logic          prev_cs   = 1'b1;
    logic          prev_sclk = 1'b0;
    int            slv_dly   = 0;
    int            rise_cnt  = 0;
    int            bad_rise  = 0;

    always @(negedge clk) begin
        prev_cs   <= cs;
        prev_sclk <= sclk;
        if (prev_cs === 1'b1 && cs === 1'b0) begin
            miso      <= slv_word[DS-1];
            slv_sh    <= slv_word << 1;
            slv_dly   <= 0;
            rise_cnt  <= 0;
            mosi_word <= '0;
        end else begin
            if (cs === 1'b0 && prev_sclk === 1'b0 && sclk === 1'b1) begin
                rise_cnt  <= rise_cnt + 1;
                mosi_word <= {mosi_word[DS-2:0], mosi};
            end
            if (cs === 1'b1 && prev_sclk === 1'b0 && sclk === 1'b1)
                bad_rise <= bad_rise + 1;
            if (cs === 1'b0 && prev_sclk === 1'b1 && sclk === 1'b0) begin
                slv_dly <= 3;
            end else if (slv_dly != 0) begin
                slv_dly <= slv_dly - 1;
                if (slv_dly == 1) begin
                    miso   <= slv_sh[DS-1];
                    slv_sh <= slv_sh << 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected {cs, sclk, ready, rx_valid} at cycle t of a frame (t=0 is the acceptance edge).
    function automatic logic [3:0] frame_exp(input int t);
        logic cs_e, sclk_e, rdy_e, val_e;
        cs_e   = !(t >= 1 && t < T_VALID);
        sclk_e = (t >= 1 + H) && (t < T_LASTF) && ((((t - 1 - H) / H) % 2) == 0);
        rdy_e  = (t >= T_READY);
        val_e  = (t == T_VALID);
        return {cs_e, sclk_e, rdy_e, val_e};
    endfunction

    task automatic run_frame(input logic [DS-1:0] tx, input logic [DS-1:0] rxw,
                             input bit hold, input logic [DS-1:0] nxt, input int pulse_t);
        chk("ready_before_frame", 32'(ready), 32'd1);
        slv_word = rxw;
        valid    = 1'b1;
        data     = tx;
        tick();
        if (hold) data = nxt;
        else valid = 1'b0;
        for (int t = 1; t <= T_READY; t++) begin
            chk($sformatf("frame_t%0d_cs_sclk_rdy_val", t), 32'({cs, sclk, ready, mvalid}), 32'(frame_exp(t)));
            if (t == T_VALID) chk("rx_data", 32'(mdata), 32'(rxw));
            if (t == pulse_t) begin
                valid = 1'b1;
                data  = 16'h1234;
            end else if (t == pulse_t + 1) begin
                valid = 1'b0;
            end
            if (t < T_READY) tick();
        end
        chk("rx_data_hold", 32'(mdata), 32'(rxw));
        chk("mosi_word", 32'(mosi_word), 32'(tx));
        chk("sclk_rise_count", 32'(rise_cnt), 32'(DS));
        chk("no_rise_cs_high", 32'(bad_rise), 32'd0);
    endtask

    initial begin
        logic [DS-1:0] w1, w2;
        rst_n = 1'b0;
        valid = 1'b0;
        data  = '0;
        tick(); tick(); tick();
        chk("rst_cs_sclk_val_rdy_mosi", 32'({cs, sclk, mvalid, ready, mosi}), 32'b10000);
        chk("rst_mdata", 32'(mdata), 32'd0);
        rst_n = 1'b1;
        chk("rst_release_ready_low", 32'(ready), 32'd0);
        tick();
        chk("rst_release_ready_high", 32'({ready, cs}), 32'b11);

        // Directed word from the datasheet example.
        run_frame(16'hA5C3, 16'h3C5A, 1'b0, '0, -1);
        for (int i = 0; i < int'($urandom_range(3, 1)); i++) tick();

        // Back-to-back frames with valid held high.
        w1 = DS'($urandom);
        w2 = DS'($urandom);
        run_frame(16'h0001, w1, 1'b1, 16'hFFFF, -1);
        run_frame(16'hFFFF, w2, 1'b0, '0, -1);

        // Valid pulse mid-frame must be ignored.
        w1 = DS'($urandom);
        w2 = DS'($urandom);
        run_frame(w1, w2, 1'b0, '0, 50);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("after_ignored_pulse_idle", 32'({cs, sclk, ready, mvalid}), 32'b1010);
        end

        // Alternating pattern with late-updating slave.
        run_frame(16'h5555, 16'hAAAA, 1'b0, '0, -1);

        // Random frames.
        for (int n = 0; n < 4; n++) begin
            w1 = DS'($urandom);
            w2 = DS'($urandom);
            run_frame(w1, w2, 1'b0, '0, -1);
            tick();
        end

        // Reset during the 8th bit.
        slv_word = DS'($urandom);
        valid    = 1'b1;
        data     = DS'($urandom);
        tick();
        valid = 1'b0;
        for (int t = 1; t < 94; t++) tick();
        chk("pre_reset_sclk_high", 32'({cs, sclk}), 32'b01);
        rst_n = 1'b0;
        tick();
        chk("midrst_cs_sclk_mosi_rdy_val", 32'({cs, sclk, mosi, ready, mvalid}), 32'b10000);
        chk("midrst_mdata", 32'(mdata), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst_release_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 110; i++) begin
            chk("post_rst_no_valid_idle", 32'({cs, sclk, mvalid}), 32'b100);
            tick();
        end
        run_frame(16'hBEEF, DS'($urandom), 1'b0, '0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
